// File: rtl/case_5_accum_pkg.sv
// Shared types and helpers for the case_5 product accumulator and its writeback neighbours.
package case_5_accum_pkg;

  localparam int unsigned ACC_W_DEF = 16;
  localparam int unsigned DIN_W_DEF = 10;

  localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_e;

  typedef struct packed {
    logic                        clamp;
    logic signed [ACC_W_DEF-1:0] sum;
  } sat_res_t;

  // Fixed-width saturating add for the default accumulator/product widths.
  function automatic sat_res_t sat_add(input logic signed [ACC_W_DEF-1:0] a,
                                       input logic signed [DIN_W_DEF-1:0] b);
    logic signed [ACC_W_DEF:0] wide;
    sat_res_t                  res;
    wide      = (ACC_W_DEF+1)'(a) + (ACC_W_DEF+1)'(b);
    res.clamp = 1'b0;
    res.sum   = wide[ACC_W_DEF-1:0];
    if (wide > (ACC_W_DEF+1)'(ACC_MAX)) begin
      res.clamp = 1'b1;
      res.sum   = ACC_MAX;
    end else if (wide < (ACC_W_DEF+1)'(ACC_MIN)) begin
      res.clamp = 1'b1;
      res.sum   = ACC_MIN;
    end
    return res;
  endfunction

endpackage

// File: rtl/case_5_sat_add.sv
// Combinational signed a + sign-extended b, clamped to the a-width range, with a clamp flag.
module case_5_sat_add #(
  parameter int unsigned A_WIDTH = 16,
  parameter int unsigned B_WIDTH = 10
) (
  input  logic signed [A_WIDTH-1:0] a,
  input  logic signed [B_WIDTH-1:0] b,
  output logic signed [A_WIDTH-1:0] sum_c,
  output logic                      clamp_c
);

  logic signed [A_WIDTH:0] wide_c;

  // One guard bit is enough: the top two bits disagree exactly when the result left the range.
  always_comb begin
    wide_c  = (A_WIDTH+1)'(a) + (A_WIDTH+1)'(b);
    clamp_c = wide_c[A_WIDTH] ^ wide_c[A_WIDTH-1];
    if (clamp_c) begin
      sum_c = {wide_c[A_WIDTH], {(A_WIDTH-1){~wide_c[A_WIDTH]}}};
    end else begin
      sum_c = wide_c[A_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/case_5_prod_accum.sv
// Groups LEN signed products into a saturating sum with a sticky per-group overflow flag,
// presented on a valid/ready output that can overlap with the next group's first product.
module case_5_prod_accum
  import case_5_accum_pkg::*;
#(
  parameter int unsigned DIN_WIDTH = 10,
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned LEN       = 8
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DIN_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic                        out_ovf
);

  localparam int unsigned            CNT_WIDTH = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_WIDTH-1:0]   CNT_LAST  = CNT_WIDTH'(LEN - 1);

  state_e                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
  logic                          ovf_q, ovf_d;
  logic                          out_valid_q, out_valid_d;
  logic signed [ACC_WIDTH-1:0]   out_data_q, out_data_d;
  logic                          out_ovf_q, out_ovf_d;

  logic signed [ACC_WIDTH-1:0]   sum_c;
  logic                          clamp_c;
  logic                          in_ready_c;
  logic                          in_fire_c;

  // acc/cnt/ovf are already zero while a result is pending, so the same adder starts a new group.
  case_5_sat_add #(
    .A_WIDTH (ACC_WIDTH),
    .B_WIDTH (DIN_WIDTH)
  ) u_sat_add (
    .a       (acc_q),
    .b       (in_data),
    .sum_c   (sum_c),
    .clamp_c (clamp_c)
  );

  assign in_ready_c = (state_q == ST_ACC) | out_ready;
  assign in_fire_c  = in_valid & in_ready_c & ~clr;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;

    if (clr) begin
      state_d = ST_ACC;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (in_fire_c) begin
      if (cnt_q == CNT_LAST) begin
        out_data_d = sum_c;
        out_ovf_d  = ovf_q | clamp_c;
        acc_d      = '0;
        cnt_d      = '0;
        ovf_d      = 1'b0;
        state_d    = ST_OUT;
      end else begin
        acc_d   = sum_c;
        cnt_d   = cnt_q + CNT_WIDTH'(1);
        ovf_d   = ovf_q | clamp_c;
        state_d = ST_ACC;
      end
    end else if ((state_q == ST_OUT) && out_ready) begin
      state_d = ST_ACC;
    end

    out_valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule
